// File: rtl/iob_wb2iob_pkg.sv
// Shared types and elaboration checks for the Wishbone-to-IOb pipelined bridge.
package iob_wb2iob_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StAck,
        StErr,
        StDrain
    } wb2iob_state_e;

    function automatic bit params_ok(input int unsigned data_w, input int unsigned timeout,
                                     input int unsigned timeout_w);
        return (data_w > 0) && (data_w % 8 == 0) && ((64'(1) << timeout_w) > 64'(timeout));
    endfunction

endpackage

// File: rtl/iob_wb2iob_timer.sv
// Response timer: cleared outside the wait phase, counts while enabled.
// TIMEOUT of 0 means the timer never expires.
module iob_wb2iob_timer #(
    parameter int unsigned TIMEOUT   = 256,
    parameter int unsigned TIMEOUT_W = 9
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [TIMEOUT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expires on the cycle that holds TIMEOUT-1, i.e. after TIMEOUT enabled cycles.
    assign expire_o = (TIMEOUT != 0) && enable_i && !clear_i
                      && (count_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/iob_wishbone2iob_pipe.sv
// Wishbone B4 slave to IOb master bridge with address window check, response
// timeout and optional pipelined stall. One transaction outstanding at a time.
module iob_wishbone2iob_pipe
    import iob_wb2iob_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       PIPELINED = 0,
    parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
    parameter logic [ADDR_W-1:0] ADDR_MASK = '0,
    parameter int unsigned       TIMEOUT   = 256,
    parameter int unsigned       TIMEOUT_W = 9
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                wb_rst_i,
    input  logic [ADDR_W-1:0]   wb_addr_i,
    input  logic [DATA_W/8-1:0] wb_select_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic [DATA_W-1:0]   wb_data_i,
    output logic                wb_ack_o,
    output logic                wb_error_o,
    output logic                wb_stall_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic                valid_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                ready_i,
    output logic                timeout_o
);

    localparam int unsigned STRB_W = DATA_W / 8;

    if (!params_ok(DATA_W, TIMEOUT, TIMEOUT_W)) begin : g_param_check
        $error("iob_wishbone2iob_pipe: illegal DATA_W/TIMEOUT/TIMEOUT_W");
    end

    wb2iob_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              we_q, we_d;
    logic              tmo_q, tmo_d;
    logic              in_range;
    logic              expire;
    logic              outstanding;

    assign in_range = (wb_addr_i & ADDR_MASK) == ADDR_BASE;

    iob_wb2iob_timer #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timer (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .clear_i  (state_q != StWait),
        .enable_i (state_q == StWait),
        .expire_o (expire)
    );

    // An IOb request is still in flight and its ready_i must be absorbed.
    assign outstanding = (state_q inside {StReq, StWait, StDrain})
                         || ((state_q == StErr) && tmo_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_d  = wb_addr_i;
                    wdata_d = wb_data_i;
                    we_d    = wb_we_i;
                    wstrb_d = wb_we_i ? wb_select_i : '0;
                    tmo_d   = 1'b0;
                    state_d = in_range ? StReq : StErr;
                end
            end
            StReq, StWait: begin
                if (!wb_cyc_i) begin
                    state_d = ready_i ? StIdle : StDrain;
                end else if (ready_i) begin
                    rdata_d = we_q ? '0 : rdata_i;
                    state_d = StAck;
                end else if (expire) begin
                    tmo_d   = 1'b1;
                    state_d = StErr;
                end else begin
                    state_d = StWait;
                end
            end
            StAck: begin
                rdata_d = '0;
                state_d = StIdle;
            end
            StErr: begin
                state_d = (tmo_q && !ready_i) ? StDrain : StIdle;
            end
            StDrain: begin
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wb_rst_i) begin
            state_d = (outstanding && !ready_i) ? StDrain : StIdle;
            addr_d  = '0;
            wdata_d = '0;
            rdata_d = '0;
            wstrb_d = '0;
            we_d    = 1'b0;
            tmo_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            tmo_q   <= tmo_d;
        end
    end

    logic req_phase;
    assign req_phase = state_q inside {StReq, StWait};

    assign valid_o    = state_q == StReq;
    assign address_o  = req_phase ? addr_q : '0;
    assign wdata_o    = req_phase ? wdata_q : '0;
    assign wstrb_o    = req_phase ? wstrb_q : '0;
    assign wb_ack_o   = state_q == StAck;
    assign wb_data_o  = (state_q == StAck) ? rdata_q : '0;
    assign wb_error_o = state_q == StErr;
    assign timeout_o  = (state_q == StErr) && tmo_q;
    assign wb_stall_o = (PIPELINED != 0) && (state_q != StIdle);

endmodule

// File: doc/iob_wishbone2iob_pipe.md
Name: iob_wishbone2iob_pipe

Overview:
Parametrised Wishbone B4 slave to IOb master bridge; successor of the single-cycle-registered WB-to-IOb adapter. Supports classic and pipelined Wishbone modes (wb_stall_o), an address-window check that returns wb_error_o, and an IOb response timeout with error termination. Sits between the Wishbone interconnect of the MAC/peripheral subsystem and IOb-native register/memory blocks. One transaction outstanding at a time.

Parameters:
ADDR_W, 32, address width (both sides)
DATA_W, 32, data width; multiple of 8; strobe width DATA_W/8
PIPELINED, 0, 0 = classic (wb_stall_o tied 0), 1 = B4 pipelined (stall while busy)
ADDR_BASE, 0, window base; request in range iff (wb_addr_i & ADDR_MASK) == ADDR_BASE
ADDR_MASK, 0, window mask; 0 accepts every address
TIMEOUT, 256, cycles to wait for ready_i before error; 0 disables timeout
TIMEOUT_W, 9, counter width; must satisfy 2^TIMEOUT_W > TIMEOUT

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
wb_rst_i  in  1  Wishbone synchronous reset, active-high
wb_addr_i  in  ADDR_W  WB address
wb_select_i  in  DATA_W/8  WB byte select
wb_we_i  in  1  WB write enable
wb_cyc_i  in  1  WB cycle
wb_stb_i  in  1  WB strobe
wb_data_i  in  DATA_W  WB write data
wb_ack_o  out  1  WB ack, registered
wb_error_o  out  1  WB error, registered
wb_stall_o  out  1  WB stall (pipelined mode only)
wb_data_o  out  DATA_W  WB read data, registered
valid_o  out  1  IOb valid
address_o  out  ADDR_W  IOb address
wdata_o  out  DATA_W  IOb write data
wstrb_o  out  DATA_W/8  IOb strobe; zero for reads
rdata_i  in  DATA_W  IOb read data
ready_i  in  1  IOb ready
timeout_o  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Reset: arst_n_i low (async) or wb_rst_i high (sync) -> state IDLE; all outputs 0; captured regs 0. Exception: wb_rst_i while IOb request outstanding (REQ/WAIT) -> DRAIN, not IDLE.
- States: IDLE, REQ, WAIT, ACK, ERR, DRAIN.
- IDLE: accept when wb_cyc_i & wb_stb_i (& ~wb_stall_o). Capture addr, data, we, strobe = we ? wb_select_i : 0. In range -> REQ; out of range -> ERR (no IOb access).
- REQ: valid_o = 1 for exactly this cycle; address_o/wdata_o/wstrb_o from capture regs (stable in REQ and WAIT, 0 otherwise). ready_i here -> ACK; else -> WAIT. Timer cleared.
- WAIT: valid_o = 0. ready_i -> ACK, latch rdata_i. Timer increments; timer reaching TIMEOUT-1 with no ready_i -> ERR with timeout_o pulse, then DRAIN instead of IDLE.
- ACK: wb_ack_o = 1 for one cycle, wb_data_o = latched rdata (0 for writes) -> IDLE. wb_data_o returns to 0 outside ACK.
- ERR: wb_error_o = 1 for one cycle -> IDLE (address error) or DRAIN (timeout).
- DRAIN: wait for late ready_i, discard rdata, no ack; then IDLE. New requests stall (pipelined) / ignored (classic) meanwhile.
- Latency: accept cycle N, valid_o N+1, earliest ack/err N+2. Address error: err at N+1.
- wb_stall_o (PIPELINED=1): 0 only in IDLE.
- Classic: master holds stb until ack/err; since ack lasts one cycle and state returns to IDLE, a still-high stb at N+3 is a new transaction.
- wb_cyc_i deasserted in REQ/WAIT: abort; no ack/err issued; go to DRAIN (or IDLE if ready_i same cycle).
- wb_ack_o and wb_error_o never both high.

Decomposition:
- Package iob_wb2iob_pkg: state encoding localparams, width checks (DATA_W%8, TIMEOUT vs TIMEOUT_W).
- Registers via existing iob_reg. One sub-module natural: iob_wb2iob_timer (clear/enable/expire counter, TIMEOUT=0 -> never expires).

Test Plan:
- Classic write addr 0x10, data 0xDEADBEEF, sel 0xF, ready_i at N+1 -> valid_o one cycle N+1, wstrb_o 0xF, wb_ack_o at N+2, wb_data_o 0.
- Classic read addr 0x20, ready_i 3 cycles after valid, rdata_i 0x12345678 -> wstrb_o 0, ack 1 cycle later with wb_data_o 0x12345678.
- PIPELINED=1, back-to-back stb for 2 reads -> stall high from N+1 until ack; second valid_o only after return to IDLE; two acks in order.
- ADDR_BASE 0x1000, ADDR_MASK 0xF000, access 0x2004 -> no valid_o, wb_error_o at N+1.
- TIMEOUT 4, ready_i never in time -> wb_error_o + timeout_o after 4 wait cycles; ready_i arriving later is discarded (no ack); next request then served normally.
- wb_rst_i in WAIT, then ready_i -> outputs 0, no ack, state IDLE afterward; arst_n_i low mid-transaction -> all outputs 0 immediately.
